// File: rtl/addsub_pkg.sv
// Shared types and helpers for the serial adder-subtractor.
// Holds the FSM encoding, operation codes and the slice-count helper.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int slice_count(input int width, input int bits_per_cyc);
    return width / bits_per_cyc;
  endfunction

endpackage

// File: rtl/full_addsub.sv
// One-bit full adder/subtractor cell: s = x +/- y +/- cb_in, with carry or borrow out.
module full_addsub
  import addsub_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic cb_in,
  input  logic sub,
  output logic s,
  output logic cb_out
);

  always_comb begin
    s = x ^ y ^ cb_in;
    if (sub == OP_SUB) begin
      // Borrow when x < y + cb_in.
      cb_out = (~x & y) | (~(x ^ y) & cb_in);
    end else begin
      cb_out = (x & y) | ((x ^ y) & cb_in);
    end
  end

endmodule

// File: rtl/serial_addsub.sv
// Multi-cycle adder-subtractor processing BITS_PER_CYC bits per cycle, LSB first.
// Optional build macro ADDSUB_SAT_EN saturates the result on signed overflow.
module serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int BITS_PER_CYC = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cb_out,
  output logic             ovf
);

  localparam int NSLICE = slice_count(WIDTH, BITS_PER_CYC);
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int IDX_W  = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

  if (WIDTH < 2 || BITS_PER_CYC < 1 || (WIDTH % BITS_PER_CYC) != 0) begin : g_bad_param
    $error("serial_addsub: WIDTH must be >= 2 and a multiple of BITS_PER_CYC");
  end

  state_t                  state, state_nxt;
  logic [WIDTH-1:0]        a_q, b_q, res_q, res_nxt;
  logic                    sub_q, cb_q, cbo_q, ovf_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [IDX_W-1:0]        base;
  logic [BITS_PER_CYC-1:0] x_sl, y_sl, s_sl;
  logic [BITS_PER_CYC:0]   chain;
  logic                    last, ovf_nxt;

  function automatic logic [WIDTH-1:0] saturate(input logic neg);
    return neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  assign base  = IDX_W'(int'(cnt_q) * BITS_PER_CYC);
  assign x_sl  = a_q[base +: BITS_PER_CYC];
  assign y_sl  = b_q[base +: BITS_PER_CYC];
  assign chain[0] = cb_q;
  assign last  = (cnt_q == LAST);
  // On the final slice the top cell is the operand MSB.
  assign ovf_nxt = chain[BITS_PER_CYC] ^ chain[BITS_PER_CYC-1];

  for (genvar i = 0; i < BITS_PER_CYC; i++) begin : g_cell
    full_addsub u_cell (
      .x     (x_sl[i]),
      .y     (y_sl[i]),
      .cb_in (chain[i]),
      .sub   (sub_q),
      .s     (s_sl[i]),
      .cb_out(chain[i+1])
    );
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    res_nxt = res_q;
    res_nxt[base +: BITS_PER_CYC] = s_sl;
`ifdef ADDSUB_SAT_EN
    if (last && ovf_nxt) res_nxt = saturate(a_q[WIDTH-1]);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt_q <= '0;
      cb_q  <= 1'b0;
      res_q <= '0;
      cbo_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (in_valid) begin
          cnt_q <= '0;
          cb_q  <= 1'b0;
          cbo_q <= 1'b0;
          ovf_q <= 1'b0;
        end
        RUN: begin
          res_q <= res_nxt;
          cb_q  <= chain[BITS_PER_CYC];
          cnt_q <= cnt_q + 1'b1;
          if (last) begin
            cbo_q <= chain[BITS_PER_CYC];
            ovf_q <= ovf_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  // Operands are captured only on acceptance; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      a_q   <= a;
      b_q   <= b;
      sub_q <= sub;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign result    = res_q;
  assign cb_out    = cbo_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub: an 8-bit/1-bit-per-cycle instance for directed
// cases and a 16-bit/4-bit-per-cycle instance for random traffic.
module tb_serial_addsub;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic        iv8 = 1'b0, ir8, sub8 = 1'b0, ov8, or8 = 1'b1, cb8, of8;
  logic [7:0]  a8 = '0, b8 = '0, r8;
  logic        iv16 = 1'b0, ir16, sub16 = 1'b0, ov16, or16 = 1'b1, cb16, of16;
  logic [15:0] a16 = '0, b16 = '0, r16;
  logic        rnd16 = 1'b0;

  serial_addsub #(.WIDTH(8), .BITS_PER_CYC(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .sub(sub8),
    .out_valid(ov8), .out_ready(or8), .result(r8), .cb_out(cb8), .ovf(of8)
  );

  serial_addsub #(.WIDTH(16), .BITS_PER_CYC(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16), .sub(sub16),
    .out_valid(ov16), .out_ready(or16), .result(r16), .cb_out(cb16), .ovf(of16)
  );

  typedef struct packed {
    logic [15:0] res;
    logic        cb;
    logic        ov;
    logic [31:0] acc;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];
  exp_t e8, e16;
  logic prev8 = 1'b0, prev16 = 1'b0;

  // Reference: plain integer add/subtract, then derive flags from the operand signs.
  function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input logic s, input int acc);
    exp_t        e;
    logic [31:0] av, bv, raw, mask, tmp;
    logic        sa, sb, sr;
    av   = {16'b0, a};
    bv   = {16'b0, b};
    mask = (32'd1 << w) - 32'd1;
    raw  = s ? (av - bv) : (av + bv);
    e.res = 16'(raw & mask);
    tmp  = raw >> w;
    e.cb = s ? (av < bv) : tmp[0];
    tmp  = av >> (w - 1);
    sa   = tmp[0];
    tmp  = bv >> (w - 1);
    sb   = tmp[0];
    tmp  = {16'b0, e.res} >> (w - 1);
    sr   = tmp[0];
    e.ov = s ? (sa != sb && sr != sa) : (sa == sb && sr != sa);
`ifdef ADDSUB_SAT_EN
    if (e.ov) e.res = sa ? 16'(32'd1 << (w - 1)) : 16'((32'd1 << (w - 1)) - 32'd1);
`endif
    e.acc = 32'(acc);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitors: compare the queue head every DONE cycle, pop on the output handshake.
  initial forever begin
    @(negedge clk);
    if (!rst_n) prev8 = 1'b0;
    else begin
      if (ov8) begin
        if (q8.size() == 0) begin
          checks++; errors++;
          $display("FAIL out8_spurious: out_valid=1 with nothing pending, expected 0");
        end else begin
          e8 = q8[0];
          if (!prev8) chk("latency8", 32'(cyc) - e8.acc, 32'd9);
          chk("result8", 32'(r8), 32'(e8.res));
          chk("cb_out8", 32'(cb8), 32'(e8.cb));
          chk("ovf8", 32'(of8), 32'(e8.ov));
          if (or8) void'(q8.pop_front());
        end
      end
      prev8 = ov8;
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst_n) prev16 = 1'b0;
    else begin
      if (ov16) begin
        if (q16.size() == 0) begin
          checks++; errors++;
          $display("FAIL out16_spurious: out_valid=1 with nothing pending, expected 0");
        end else begin
          e16 = q16[0];
          if (!prev16) chk("latency16", 32'(cyc) - e16.acc, 32'd5);
          chk("result16", 32'(r16), 32'(e16.res));
          chk("cb_out16", 32'(cb16), 32'(e16.cb));
          chk("ovf16", 32'(of16), 32'(e16.ov));
          if (or16) void'(q16.pop_front());
        end
      end
      prev16 = ov16;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rnd16) or16 = ($urandom_range(0, 3) != 0);
  end

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic s);
    bit done = 0;
    @(posedge clk); #1;
    iv8 = 1'b1; a8 = a; b8 = b; sub8 = s;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (ir8) begin
        q8.push_back(model(8, {8'b0, a}, {8'b0, b}, s, cyc));
        done = 1;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL issue8_timeout: in_ready stayed 0 for 100 cycles, expected 1");
    end
    @(posedge clk); #1;
    iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
  endtask

  task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic s);
    bit done = 0;
    @(posedge clk); #1;
    iv16 = 1'b1; a16 = a; b16 = b; sub16 = s;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (ir16) begin
        q16.push_back(model(16, a, b, s, cyc));
        done = 1;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL issue16_timeout: in_ready stayed 0 for 100 cycles, expected 1");
    end
    @(posedge clk); #1;
    iv16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); sub16 = 1'($urandom);
  endtask

  task automatic drain8();
    for (int i = 0; i < 300 && q8.size() != 0; i++) @(negedge clk);
    if (q8.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain8_timeout: %0d results pending, expected 0", q8.size());
      q8.delete();
    end
  endtask

  task automatic drain16();
    for (int i = 0; i < 600 && q16.size() != 0; i++) @(negedge clk);
    if (q16.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain16_timeout: %0d results pending, expected 0", q16.size());
      q16.delete();
    end
  endtask

  logic [7:0] ta [5] = '{8'h05, 8'h03, 8'hFF, 8'h7F, 8'h80};
  logic [7:0] tb [5] = '{8'h03, 8'h05, 8'h01, 8'h01, 8'h01};
  logic       ts [5] = '{1'b1,  1'b1,  1'b0,  1'b0,  1'b1};

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready8", 32'(ir8), 32'd1);
    chk("rst_out_valid8", 32'(ov8), 32'd0);
    chk("rst_result8", 32'(r8), 32'd0);
    chk("rst_cb8", 32'(cb8), 32'd0);
    chk("rst_ovf8", 32'(of8), 32'd0);
    chk("rst_in_ready16", 32'(ir16), 32'd1);
    chk("rst_out_valid16", 32'(ov16), 32'd0);
    chk("rst_result16", 32'(r16), 32'd0);

    for (int i = 0; i < 5; i++) begin
      issue8(ta[i], tb[i], ts[i]);
      drain8();
    end
    for (int i = 0; i < 40; i++) issue8(8'($urandom), 8'($urandom), 1'($urandom));
    drain8();

    // Back-pressure: hold the result while new operands wait on in_valid.
    @(posedge clk); #1 or8 = 1'b0;
    issue8(8'h12, 8'h34, 1'b0);
    for (int i = 0; i < 50 && !ov8; i++) @(negedge clk);
    @(posedge clk); #1;
    iv8 = 1'b1; a8 = 8'h55; b8 = 8'h11; sub8 = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("hold_in_ready8", 32'(ir8), 32'd0);
      chk("hold_out_valid8", 32'(ov8), 32'd1);
    end
    @(posedge clk); #1 or8 = 1'b1;
    issue8(8'h55, 8'h11, 1'b0);
    drain8();

    // Reset in the fourth RUN cycle abandons the operation.
    issue8(8'h21, 8'h04, 1'b1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    q8.delete();
    @(negedge clk);
    chk("midrst_in_ready8", 32'(ir8), 32'd1);
    chk("midrst_out_valid8", 32'(ov8), 32'd0);
    chk("midrst_result8", 32'(r8), 32'd0);
    chk("midrst_cb8", 32'(cb8), 32'd0);
    chk("midrst_ovf8", 32'(of8), 32'd0);
    issue8(8'h10, 8'h01, 1'b1);
    drain8();

    rnd16 = 1'b1;
    for (int i = 0; i < 1000; i++) issue16(16'($urandom), 16'($urandom), 1'($urandom));
    drain16();
    rnd16 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
Parametrised, multi-cycle, unsigned/two's-complement adder-subtractor built around a shared 1-bit full add/subtract cell. It is the sequential successor to the team's 1-bit half/full subtractor cells. Operands are processed LSB-first in BITS_PER_CYC-bit slices, with a carry/borrow flip-flop between slices. The block sits in the combinational_ckt arithmetic group as the area-optimised alternative to a flat ripple adder-subtractor, behind a valid/ready handshake.

Parameters:
WIDTH, 8, operand and result width in bits; must be at least 2.
BITS_PER_CYC, 1, bits processed per cycle; must divide WIDTH exactly. An illegal value is flagged by an elaboration-time check.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous, active-low reset
in_valid  input  1  operand transfer request
in_ready  output  1  block can accept operands
a  input  WIDTH  minuend / augend
b  input  WIDTH  subtrahend / addend
sub  input  1  1 = a-b, 0 = a+b; sampled with the operands
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
result  output  WIDTH  sum or difference, modulo 2^WIDTH
cb_out  output  1  carry-out (add) or borrow-out (sub, 1 when a<b unsigned)
ovf  output  1  signed two's-complement overflow

Behaviour:
- Clock and reset: single clock domain, clk. rst_n is synchronous and active-low.
- Reset state (rst_n=0 at a clk edge): state IDLE, in_ready=1, out_valid=0, result=0, cb_out=0, ovf=0, slice counter=0, carry/borrow FF=0.
- FSM states:
  - IDLE: in_ready=1. When in_valid&in_ready, latch a, b and sub, clear the carry/borrow FF and the counter, then go to RUN.
  - RUN: in_ready=0. Each cycle, one BITS_PER_CYC slice (LSB first) goes through a chain of BITS_PER_CYC full_addsub cells. The slice output is written into result; the chain's last carry/borrow goes into the FF. The counter increments. After slice WIDTH/BITS_PER_CYC-1, go to DONE.
  - DONE: out_valid=1. result, cb_out and ovf are held stable while out_valid=1 and out_ready=0. On out_valid&out_ready, go to IDLE with out_valid=0 on the next cycle.
- Latency: from the in_valid&in_ready edge to the first out_valid=1 cycle is WIDTH/BITS_PER_CYC + 1 cycles. Throughput is one operation per WIDTH/BITS_PER_CYC + 2 cycles with out_ready tied high.
- No new operands are accepted in RUN or DONE. in_valid stays ignored until in_ready=1; there is no bypass.
- Arithmetic:
  - add: sum = a + b; cb_out = carry out of the MSB.
  - sub: diff = a - b, computed as direct borrow-chain subtraction (not invert+1); cb_out = borrow out of the MSB.
  - ovf = carry/borrow into the MSB XOR carry/borrow out of the MSB.
  - All three outputs become visible together when DONE is entered.
- result may hold partial values during RUN. Consumers read it only when out_valid=1.
- Reset mid-operation: rst_n=0 in RUN or DONE discards the operation and returns to IDLE with all outputs at reset values. No out_valid pulse is produced.
- Operand changes on a/b/sub after acceptance have no effect.

Optional Feature:
- Macro: ADDSUB_SAT_EN.
- Defined: when ovf=1, result saturates:
  - positive overflow → 0111…1
  - negative overflow → 1000…0
  - Sign of the saturation is taken from the MSB of a.
  - ovf and cb_out still report the raw arithmetic.
- Undefined: result wraps modulo 2^WIDTH. No saturation logic is built.

Decomposition:
- Shared package addsub_pkg:
  - state typedef with encodings IDLE=2'b00, RUN=2'b01, DONE=2'b10
  - OP_ADD=1'b0, OP_SUB=1'b1
  - function computing the slice count WIDTH/BITS_PER_CYC
- Sub-module full_addsub: 1-bit combinational cell with inputs x, y, cb_in, sub and outputs s, cb_out. The generalised full adder/subtractor is instantiated BITS_PER_CYC times in a generate loop.

Test Plan:
1. WIDTH=8, BITS_PER_CYC=1: sub, a=0x05, b=0x03 → result=0x02, cb_out=0, ovf=0; out_valid rises exactly 9 cycles after acceptance.
2. Sub, a=0x03, b=0x05 → result=0xFE, cb_out=1, ovf=0. Add, a=0xFF, b=0x01 → result=0x00, cb_out=1, ovf=0.
3. Add, a=0x7F, b=0x01 → result=0x80 (0x7F with ADDSUB_SAT_EN), ovf=1. Sub, a=0x80, b=0x01 → result=0x7F (0x80 with ADDSUB_SAT_EN), ovf=1, cb_out=0.
4. Hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands → result stable, in_ready=0, second operation not accepted until after the out handshake.
5. Assert rst_n=0 for one cycle on the 4th RUN cycle → next cycle in_ready=1, out_valid=0, result=0. A following sub 0x10-0x01 completes with 0x0F.
6. WIDTH=16, BITS_PER_CYC=4: random 1000 add/sub ops against a reference model → result, cb_out and ovf match; latency is 5 cycles each.
